// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit with HI/LO registers (E stage).
// Ports: clk, reset (async, active-low), start/op/a/b (MD op from D->E),
//        busy (to D-stage stall), hi/lo (registers), rd_data (MFHI/MFLO read).
// Optional: define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (ops 9-12).
module mul_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    localparam int NMAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(NMAX + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    op_q;
    logic [31:0]   a_q, b_q;
    logic [31:0]   hi_q, lo_q;
    logic          busy_q;

    logic          is_mul, is_div;
    logic [63:0]   acc, prod_s, prod_u, res_d;
    logic signed [31:0] q_s, r_s;

    // Decode of the incoming op; only these start a busy sequence.
    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        case (op)
            OP_MULT, OP_MULTU: is_mul = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU,
            OP_MSUB, OP_MSUBU: is_mul = 1'b1;
`endif
            OP_DIV, OP_DIVU:   is_div = 1'b1;
            default: ;
        endcase
    end

    // Result computed from latched operands; hi/lo cannot change while busy,
    // so the accumulate base here equals the value at accept.
    always_comb begin
        acc    = {hi_q, lo_q};
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        q_s    = '0;
        r_s    = '0;
        res_d  = acc;
        case (op_q)
            OP_MULT:  res_d = prod_s;
            OP_MULTU: res_d = prod_u;
            OP_DIV: begin
                if (b_q == 32'd0) begin
                    res_d = acc;
                end else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
                    // Quotient overflows; wraps to the dividend, no remainder.
                    res_d = {32'd0, 32'h8000_0000};
                end else begin
                    q_s   = $signed(a_q) / $signed(b_q);
                    r_s   = $signed(a_q) % $signed(b_q);
                    res_d = {r_s, q_s};
                end
            end
            OP_DIVU: begin
                if (b_q != 32'd0)
                    res_d = {a_q % b_q, a_q / b_q};
            end
`ifdef MDU_MADD_EN
            OP_MADD:  res_d = acc + prod_s;
            OP_MADDU: res_d = acc + prod_u;
            OP_MSUB:  res_d = acc - prod_s;
            OP_MSUBU: res_d = acc - prod_u;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && (is_mul || is_div)) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        cnt_q   <= is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                        busy_q  <= 1'b1;
                        state_q <= S_BUSY;
                    end else if (start && op == OP_MTHI) begin
                        hi_q <= a;
                    end else if (start && op == OP_MTLO) begin
                        lo_q <= a;
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        {hi_q, lo_q} <= res_d;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_comb begin
        rd_data = 32'd0;
        if (op == OP_MFHI)
            rd_data = hi_q;
        else if (op == OP_MFLO)
            rd_data = lo_q;
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized + directed bench for mul_div_unit against a
// transaction-level model (result computed at accept, applied N cycles later).
module tb_mul_div_unit;

    localparam int MULN = 5;
    localparam int DIVN = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] hi, lo, rd_data;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .hi(hi), .lo(lo), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_hi = 0, m_lo = 0;
    int          m_left = 0;
    bit          m_wr = 0;
    bit   [63:0] m_res = 0;

    function automatic bit [63:0] smul(input bit [31:0] x, input bit [31:0] y);
        longint sx = $signed(x);
        longint sy = $signed(y);
        return sx * sy;
    endfunction

    function automatic bit [63:0] umul(input bit [31:0] x, input bit [31:0] y);
        longint unsigned ux = x;
        longint unsigned uy = y;
        return ux * uy;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi = 0; m_lo = 0; m_left = 0; m_wr = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_wr) begin
                m_hi = m_res[63:32];
                m_lo = m_res[31:0];
            end
        end else if (start) begin
            longint la, lb;
            m_wr = 1;
            case (op)
                4'd1: begin m_left = MULN; m_res = smul(a, b); end
                4'd2: begin m_left = MULN; m_res = umul(a, b); end
                4'd3: begin
                    m_left = DIVN;
                    la = $signed(a); lb = $signed(b);
                    if (b == 0) m_wr = 0;
                    else m_res = {32'(la % lb), 32'(la / lb)};
                end
                4'd4: begin
                    m_left = DIVN;
                    la = a; lb = b;
                    if (b == 0) m_wr = 0;
                    else m_res = {32'(la % lb), 32'(la / lb)};
                end
                4'd7: m_hi = a;
                4'd8: m_lo = a;
`ifdef MDU_MADD_EN
                4'd9:  begin m_left = MULN; m_res = {m_hi, m_lo} + smul(a, b); end
                4'd10: begin m_left = MULN; m_res = {m_hi, m_lo} + umul(a, b); end
                4'd11: begin m_left = MULN; m_res = {m_hi, m_lo} - smul(a, b); end
                4'd12: begin m_left = MULN; m_res = {m_hi, m_lo} - umul(a, b); end
`endif
                default: ;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (reset) begin
            logic [31:0] exp_rd;
            exp_rd = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
            chk("busy", {31'd0, busy}, {31'd0, (m_left != 0)});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            chk("rd_data", rd_data, exp_rd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit s, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        start = s; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 4'd0;
    endtask

    // Counts cycles busy stays high, starting just after the accept edge.
    task automatic busy_len(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        if (n >= 100) begin
            errors++;
            $display("FAIL busy_timeout got=%0d expected=<100", n);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        #12 reset = 1'b1;
        @(posedge clk); #1;
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);

        // MULT -3 * 5
        cyc(1, 4'd1, 32'hFFFF_FFFD, 32'd5);
        busy_len(n);
        chk("mult_len", n, MULN);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);

        // DIVU 17 / 5, DIV -17 / 5
        cyc(1, 4'd4, 32'd17, 32'd5);
        busy_len(n);
        chk("divu_len", n, DIVN);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd2);
        cyc(1, 4'd3, 32'hFFFF_FFEF, 32'd5);
        busy_len(n);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFE);

        // MTHI then divide by zero
        cyc(1, 4'd7, 32'h1234, 32'd0);
        chk("mthi", hi, 32'h1234);
        cyc(1, 4'd3, 32'd99, 32'd0);
        busy_len(n);
        chk("div0_len", n, DIVN);
        chk("div0_hi", hi, 32'h1234);
        chk("div0_lo", lo, 32'hFFFF_FFFD);

        // Overflow case
        cyc(1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        busy_len(n);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'd0);

        // Ops issued while busy are ignored
        cyc(1, 4'd1, 32'd7, 32'd6);
        cyc(1, 4'd8, 32'hAAAA, 32'd0);
        cyc(1, 4'd1, 32'd100, 32'd100);
        busy_len(n);
        chk("ign_lo", lo, 32'd42);
        chk("ign_hi", hi, 32'd0);

        // Start in the completion cycle is ignored
        cyc(1, 4'd2, 32'd2, 32'd3);
        for (int i = 0; i < MULN - 1; i++) cyc(0, 4'd0, 0, 0);
        cyc(1, 4'd7, 32'hBEEF, 32'd0);
        chk("cmpl_busy", {31'd0, busy}, 32'd0);
        chk("cmpl_hi", hi, 32'd0);
        chk("cmpl_lo", lo, 32'd6);

        // MFHI read
        op = 4'd5; #1;
        chk("mfhi", rd_data, 32'd0);
        op = 4'd6; #1;
        chk("mflo", rd_data, 32'd6);
        op = 4'd0;

        // Reset mid-DIV
        cyc(1, 4'd4, 32'd100, 32'd7);
        cyc(0, 4'd0, 0, 0);
        cyc(0, 4'd0, 0, 0);
        reset = 1'b0; #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < DIVN + 2; i++) cyc(0, 4'd0, 0, 0);
        op = 4'd6; #1;
        chk("rst_mflo", rd_data, 32'd0);
        op = 4'd0;

        // MADDU carry into hi
        cyc(1, 4'd7, 32'd0, 32'd0);
        cyc(1, 4'd8, 32'hFFFF_FFFF, 32'd0);
        cyc(1, 4'd10, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        busy_len(n);
        chk("maddu_len", n, MULN);
        chk("maddu_hi", hi, 32'd1);
        chk("maddu_lo", lo, 32'd0);
`else
        chk("maddu_busy", {31'd0, busy}, 32'd0);
        chk("maddu_hi", hi, 32'd0);
        chk("maddu_lo", lo, 32'hFFFF_FFFF);
`endif

        // Random traffic, model compare runs every cycle
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), pick(), pick());
            if ($urandom_range(0, 4) == 0) begin
                a = $urandom; b = $urandom; #1;
            end
        end
        for (int i = 0; i < DIVN + 2; i++) cyc(0, 4'd0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
